// File: rtl/signnarrow_pkg.sv
// Shared types for the signnarrow streaming narrower.
// Skid-buffer occupancy states live here; entry layout is per-module.
package signnarrow_pkg;

    // Occupancy of the two-entry skid buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } signnarrow_state_t;

    // Each buffer entry pairs a narrowed value with its overflow flag:
    //   struct packed { logic [N-1:0] data; logic ovf; }
    // N is a module parameter, so modules declare the struct locally.

endpackage

// File: rtl/signnarrow_sat.sv
// Combinational M-to-N signed narrowing core with saturation.
// Build with SIGNNARROW_WRAP_EN defined for plain truncation instead.
module signnarrow_sat
    import signnarrow_pkg::*;
#(
    parameter int N = 3,
    parameter int M = 5
) (
    input  logic [M-1:0] i_x,
    output logic [N-1:0] o_y,
    output logic         o_ovf
);

    logic [M-N:0] top_bits;
    logic         fit;

    assign top_bits = i_x[M-1:N-1];
    assign fit      = (&top_bits) | ~(|top_bits);

    // Narrow the value; out-of-range inputs clamp or wrap
    always_comb begin
        o_ovf = ~fit;
`ifdef SIGNNARROW_WRAP_EN
        o_y   = i_x[N-1:0];
`else
        if (fit) begin
            o_y = i_x[N-1:0];
        end else if (i_x[M-1]) begin
            o_y = {1'b1, {(N-1){1'b0}}};
        end else begin
            o_y = {1'b0, {(N-1){1'b1}}};
        end
`endif
    end

endmodule

// File: rtl/signnarrow.sv
// Streaming signed narrower with 2-entry skid buffer and overflow stats.
// Define SIGNNARROW_WRAP_EN to truncate instead of saturating.
module signnarrow
    import signnarrow_pkg::*;
#(
    parameter int N     = 3,
    parameter int M     = 5,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [M-1:0]     i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [N-1:0]     o_data,
    output logic             o_ovf,
    output logic             o_sticky_ovf,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_ovf_cnt
);

    typedef struct packed {
        logic [N-1:0] data;
        logic         ovf;
    } entry_t;

    signnarrow_state_t state;
    entry_t            head;
    entry_t            skid;
    entry_t            conv;
    logic              acc;
    logic              xfer;

    signnarrow_sat #(
        .N (N),
        .M (M)
    ) u_sat (
        .i_x   (i_data),
        .o_y   (conv.data),
        .o_ovf (conv.ovf)
    );

    assign acc    = i_valid && o_ready;
    assign xfer   = o_valid && i_ready;
    assign o_data = head.data;
    assign o_ovf  = head.ovf;

    // Skid-buffer FSM with registered valid/ready
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= EMPTY;
            head    <= '0;
            skid    <= '0;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        head    <= conv;
                        state   <= ONE;
                        o_valid <= 1'b1;
                        o_ready <= 1'b1;
                    end
                end
                ONE: begin
                    if (acc && xfer) begin
                        head <= conv;
                    end else if (acc) begin
                        skid    <= conv;
                        state   <= TWO;
                        o_ready <= 1'b0;
                    end else if (xfer) begin
                        state   <= EMPTY;
                        o_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (xfer) begin
                        head    <= skid;
                        state   <= ONE;
                        o_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

    // Overflow statistics on delivered beats; clear wins over update
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_sticky_ovf <= 1'b0;
            o_ovf_cnt    <= '0;
        end else if (i_clr) begin
            o_sticky_ovf <= 1'b0;
            o_ovf_cnt    <= '0;
        end else if (xfer && head.ovf) begin
            o_sticky_ovf <= 1'b1;
            if (o_ovf_cnt != {CNT_W{1'b1}}) begin
                o_ovf_cnt <= o_ovf_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_signnarrow.sv
// Directed self-checking bench for signnarrow (N=3, M=5).
// A second instance with CNT_W=2 shares the stimulus.
module tb_signnarrow;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       rdy;
    logic [4:0] in_data;
    logic       out_valid;
    logic       ds_ready;
    logic [2:0] out_data;
    logic       ovf;
    logic       sticky;
    logic       clr;
    logic [7:0] cnt;

    logic       rdy2;
    logic       out_valid2;
    logic [2:0] out_data2;
    logic       ovf2;
    logic       sticky2;
    logic [1:0] cnt2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    signnarrow #(.N(3), .M(5), .CNT_W(8)) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (in_valid),
        .o_ready      (rdy),
        .i_data       (in_data),
        .o_valid      (out_valid),
        .i_ready      (ds_ready),
        .o_data       (out_data),
        .o_ovf        (ovf),
        .o_sticky_ovf (sticky),
        .i_clr        (clr),
        .o_ovf_cnt    (cnt)
    );

    signnarrow #(.N(3), .M(5), .CNT_W(2)) u_dut2 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (in_valid),
        .o_ready      (rdy2),
        .i_data       (in_data),
        .o_valid      (out_valid2),
        .i_ready      (ds_ready),
        .o_data       (out_data2),
        .o_ovf        (ovf2),
        .o_sticky_ovf (sticky2),
        .i_clr        (clr),
        .o_ovf_cnt    (cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {ovf, data} for a 5-bit input narrowed to 3 bits
    function automatic logic [3:0] model(input logic [4:0] x);
        logic       fit;
        logic [2:0] y;
        fit = (x[4:2] == 3'b000) || (x[4:2] == 3'b111);
`ifdef SIGNNARROW_WRAP_EN
        y = x[2:0];
`else
        if (fit)       y = x[2:0];
        else if (x[4]) y = 3'b100;
        else           y = 3'b011;
`endif
        return {~fit, y};
    endfunction

    logic [3:0] ov_a;
    logic [3:0] ov_b;

    initial begin
`ifdef SIGNNARROW_WRAP_EN
        ov_a = 4'b1010;
        ov_b = 4'b1110;
`else
        ov_a = 4'b1011;
        ov_b = 4'b1100;
`endif
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        ds_ready = 1'b1;
        clr      = 1'b0;
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_ready", rdy, 1);
        check("rst_data", out_data, 0);
        check("rst_ovf", ovf, 0);
        check("rst_sticky", sticky, 0);
        check("rst_cnt", cnt, 0);
        rst_n = 1'b1;
        tick();

        // In-range pass-through
        in_valid = 1'b1;
        in_data  = 5'b00011;
        tick();
        check("fit_pos", {out_valid, ovf, out_data}, 5'b10011);
        in_data = 5'b11101;
        tick();
        check("fit_neg", {out_valid, ovf, out_data}, 5'b10101);
        in_valid = 1'b0;
        tick();
        check("fit_drain", out_valid, 0);
        check("fit_cnt", cnt, 0);

        // Overflow in both directions
        in_valid = 1'b1;
        in_data  = 5'b01010;
        tick();
        check("ovf_pos", {ovf, out_data}, ov_a);
        in_data = 5'b10110;
        tick();
        check("ovf_neg", {ovf, out_data}, ov_b);
        in_valid = 1'b0;
        tick();
        check("ovf_sticky", sticky, 1);
        check("ovf_cnt", cnt, 2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_cnt", cnt, 0);
        check("clr_sticky", sticky, 0);

        // Exhaustive back-to-back sweep
        in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            logic [3:0] e;
            v = 5'(i);
            in_data = v;
            e = model(v);
            tick();
            check($sformatf("sweep_%0d", i),
                  {out_valid, ovf, out_data}, {1'b1, e});
            if (!ovf)
                check($sformatf("sext_%0d", i),
                      {{2{out_data[2]}}, out_data}, v);
        end
        in_valid = 1'b0;
        tick();
        check("sweep_cnt", cnt, 24);
        check("sweep_cnt2", cnt2, 3);
        check("sweep_empty", out_valid, 0);

        // Backpressure: two beats held, third refused
        clr = 1'b1;
        tick();
        clr      = 1'b0;
        ds_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = 5'b00001;
        tick();
        check("bp_one_rdy", rdy, 1);
        in_data = 5'b11111;
        tick();
        check("bp_two_rdy", rdy, 0);
        check("bp_head", out_data, 3'b001);
        in_data = 5'b00010;
        tick();
        check("bp_hold_rdy", rdy, 0);
        check("bp_stable1", {out_valid, out_data}, 4'b1001);
        tick();
        check("bp_stable2", {out_valid, out_data}, 4'b1001);
        ds_ready = 1'b1;
        tick();
        check("bp_out2", out_data, 3'b111);
        check("bp_rdy_back", rdy, 1);
        tick();
        check("bp_out3", {out_valid, out_data}, 4'b1010);
        in_valid = 1'b0;
        tick();
        check("bp_drain", out_valid, 0);

        // Counter saturation on the narrow instance, then clear race
        clr = 1'b1;
        tick();
        clr      = 1'b0;
        in_valid = 1'b1;
        in_data  = 5'b01111;
        repeat (5) tick();
        in_valid = 1'b0;
        tick();
        check("sat_cnt2", cnt2, 3);
        check("sat_cnt", cnt, 5);
        check("sat_sticky2", sticky2, 1);
        in_valid = 1'b1;
        tick();
        check("sixth_head", {out_valid2, ovf2}, 2'b11);
        in_valid = 1'b0;
        clr      = 1'b1;
        tick();
        clr = 1'b0;
        check("race_cnt2", cnt2, 0);
        check("race_sticky2", sticky2, 0);
        check("race_cnt", cnt, 0);

        // Reset while full
        in_valid = 1'b1;
        in_data  = 5'b10000;
        tick();
        in_valid = 1'b0;
        tick();
        check("pre_rst_cnt", cnt, 1);
        ds_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = 5'b01000;
        tick();
        tick();
        check("pre_rst_full", rdy, 0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        check("rst2_valid", out_valid, 0);
        check("rst2_ready", rdy, 1);
        check("rst2_cnt", cnt, 0);
        rst_n    = 1'b1;
        ds_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("no_stale_%0d", k), out_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
